mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers of the P6 MIPS core.
// Operands are latched at start; HI/LO change only at the completion edge or on MTHI/MTLO.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOP,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        latch;
    logic [31:0] hi_next, lo_next;
    logic [63:0] prod, quot;

    // Full 64-bit product; unsigned operands are zero-extended so the low 64 bits match.
    function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic is_signed);
        logic signed [63:0] sa, sb;
        sa = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        sb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return sa * sb;
    endfunction

    // Returns {remainder, quotient}; signed case works on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 without overflow.
    function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                             input logic is_signed);
        logic        neg_a, neg_b;
        logic [31:0] ua, ub, uq, ur;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        uq    = ua / ub;
        ur    = ua % ub;
        return {(neg_a ? -ur : ur), ((neg_a ^ neg_b) ? -uq : uq)};
    endfunction

    assign prod = mul_full(a_q, b_q, op_q == OP_MULT);
    assign quot = div_full(a_q, b_q, op_q == OP_DIV);
    assign busy = (state == RUN);

    always_comb begin
        state_next = state;
        count_next = count;
        latch      = 1'b0;
        hi_next    = HI;
        lo_next    = LO;
        case (state)
            IDLE: begin
                if (start) begin
                    case (MDUOP)
                        OP_MULT, OP_MULTU: begin
                            latch      = 1'b1;
                            count_next = 4'(MULT_CYCLES);
                            state_next = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            latch      = 1'b1;
                            count_next = 4'(DIV_CYCLES);
                            state_next = RUN;
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                count_next = count - 4'd1;
                if (count <= 4'd1) begin
                    count_next = 4'd0;
                    state_next = IDLE;
                    if (op_q == OP_MULT || op_q == OP_MULTU) begin
                        {hi_next, lo_next} = prod;
                    end else if (b_q != 32'd0) begin
                        {hi_next, lo_next} = quot;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (latch) begin
                op_q <= MDUOP;
                a_q  <= A;
                b_q  <= B;
            end
            HI <= hi_next;
            LO <= lo_next;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized operations
// compared against a 64-bit arithmetic reference model of HI/LO and busy timing.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  MDUOP;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_hi, exp_lo;

    mult_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .B    (B),
        .MDUOP(MDUOP),
        .start(start),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: plain 64-bit arithmetic on the operands as given at start.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                q = ua / ub; r = ua % ub; exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        int n;
        logic [31:0] old_hi, old_lo;
        n = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        start = 1'b1; MDUOP = op; A = a; B = b;
        model(op, a, b);
        @(posedge clk);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start = 1'b0; MDUOP = 3'd0;
            A = $urandom; B = $urandom;
            check($sformatf("busy_run op%0d c%0d", op, i), {31'd0, busy}, 32'd1);
            check($sformatf("hi_hold op%0d c%0d", op, i), HI, old_hi);
            check($sformatf("lo_hold op%0d c%0d", op, i), LO, old_lo);
            if (disturb && i == 3) begin
                start = 1'b1; MDUOP = 3'd6; A = 32'hDEADBEEF;
            end
            if (disturb && i == n) begin
                start = 1'b1; MDUOP = 3'd5; A = $urandom;
            end
        end
        @(negedge clk);
        start = 1'b0; MDUOP = 3'd0;
        check($sformatf("busy_done op%0d", op), {31'd0, busy}, 32'd0);
        check($sformatf("hi_res op%0d", op), HI, exp_hi);
        check($sformatf("lo_res op%0d", op), LO, exp_lo);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; MDUOP = op; A = a;
        if (op == 3'd5) exp_hi = a;
        else if (op == 3'd6) exp_lo = a;
        @(negedge clk);
        start = 1'b0; MDUOP = 3'd0;
        check($sformatf("mt_busy op%0d", op), {31'd0, busy}, 32'd0);
        check($sformatf("mt_hi op%0d", op), HI, exp_hi);
        check($sformatf("mt_lo op%0d", op), LO, exp_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        n_checks = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; MDUOP = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;

        run_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
        check("mult_hi_const", HI, 32'hFFFFFFFF);
        check("mult_lo_const", LO, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'h2, 1'b0);
        check("multu_hi_const", HI, 32'h00000001);
        check("multu_lo_const", LO, 32'hFFFFFFFE);
        run_op(3'd3, 32'hFFFFFFF9, 32'h2, 1'b0);
        check("div_lo_const", LO, 32'hFFFFFFFD);
        check("div_hi_const", HI, 32'hFFFFFFFF);
        run_op(3'd4, 32'd7, 32'd2, 1'b0);
        check("divu_lo_const", LO, 32'd3);
        check("divu_hi_const", HI, 32'd1);

        // Back-to-back MTHI then MTLO.
        @(negedge clk);
        start = 1'b1; MDUOP = 3'd5; A = 32'h12345678;
        @(negedge clk);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        MDUOP = 3'd6; A = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; MDUOP = 3'd0;
        exp_hi = 32'h12345678; exp_lo = 32'h9ABCDEF0;
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mthilo_hi", HI, 32'h12345678);
        check("mthilo_lo", LO, 32'h9ABCDEF0);

        run_op(3'd3, 32'd1234, 32'd0, 1'b0);
        check("div0_hi", HI, 32'h12345678);
        check("div0_lo", LO, 32'h9ABCDEF0);

        run_op(3'd1, 32'h00012345, 32'hFFFF0003, 1'b1);

        // Reset aborts an in-flight divide.
        @(negedge clk);
        start = 1'b1; MDUOP = 3'd3; A = 32'd100; B = 32'd3;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0; MDUOP = 3'd0;
            check($sformatf("abort_busy c%0d", i), {31'd0, busy}, 32'd1);
            if (i == 4) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("abort_busy_after", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_busy_late", {31'd0, busy}, 32'd0);
        check("abort_hi_late", HI, 32'd0);
        check("abort_lo_late", LO, 32'd0);

        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lo", LO, 32'h80000000);
        check("div_ovf_hi", HI, 32'd0);

        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            if (rop >= 3'd1 && rop <= 3'd4) run_op(rop, ra, rb, $urandom_range(0, 1) == 1);
            else mt(rop, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
